// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared types and constants for the 32-bit restoring divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [WIDTH-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_restoring32_sub.sv
// ---------------------------------------------------------------------------
// Sub : 32-bit ripple-borrow subtractor built from eight 4-bit borrow cells
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module Sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] diff,
  output logic        borrow
);

  logic [8:0] w_bc;

  assign w_bc[0] = cin;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_cell
      logic [4:0] w_res;
      // Bit 4 of the 5-bit wrapped result is set exactly when a - b - bin < 0
      assign w_res = {1'b0, a[4*i+3:4*i]} - {1'b0, b[4*i+3:4*i]} - {4'b0000, w_bc[i]};
      assign diff[4*i+3:4*i] = w_res[3:0];
      assign w_bc[i+1]       = w_res[4];
    end
  endgenerate

  assign borrow = w_bc[8];

endmodule : Sub

`default_nettype wire

// File: rtl/div_restoring32.sv
// ---------------------------------------------------------------------------
// div_restoring32 : 32-bit unsigned restoring divider, one quotient bit/clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_restoring32
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 ready,
  output logic                 valid,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_r;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dbz;

  logic [WIDTH:0]     w_s;
  logic [WIDTH-1:0]   w_diff;
  logic               w_borrow;
  logic               w_accept;

  // The partial remainder's bit 32 is always zero after an iteration: a
  // rejected step implies S[32]=0, so only the low 32 bits are stored.
  assign w_s      = {r_r, r_q[WIDTH-1]};
  assign w_accept = w_s[WIDTH] | ~w_borrow;

  Sub u_sub (
    .a      (w_s[WIDTH-1:0]),
    .b      (r_d),
    .cin    (1'b0),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      ready       <= 1'b1;
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= CNT_W'(WIDTH - 1);
            ready <= 1'b0;
            if (divisor == '0) begin
              r_dbz   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_r <= w_diff;
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= w_s[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // On divide-by-zero r_q still holds the untouched dividend
          quotient    <= r_dbz ? DBZ_QUOT : r_q;
          remainder   <= r_dbz ? r_q : r_r;
          div_by_zero <= r_dbz;
          valid       <= 1'b1;
          ready       <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          ready   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : div_restoring32

`default_nettype wire

// File: tb/tb_div_restoring32.sv
// ---------------------------------------------------------------------------
// tb_div_restoring32 : self-checking bench for the restoring divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_restoring32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  div_restoring32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; edges after accept until valid is seen
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == 32'd0) begin
      v.q = 32'hFFFF_FFFF; v.r = a; v.dbz = 1'b1; v.lat = 1;
    end else begin
      v.q = a / b; v.r = a % b; v.dbz = 1'b0; v.lat = 33;
    end
    return v;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dbz, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    chk("ready_drop", {31'b0, ready}, 32'd0);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
    q = quotient; r = remainder; dbz = div_by_zero;
    @(posedge clk); #1;
    chk("valid_pulse", {31'b0, valid}, 32'd0);
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    logic [31:0] q, r;
    logic        dbz;
    int          lat;
    run_op(v.a, v.b, q, r, dbz, lat);
    chk({tag, "_quot"}, q, v.q);
    chk({tag, "_rem"}, r, v.r);
    chk({tag, "_dbz"}, {31'b0, dbz}, {31'b0, v.dbz});
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          vcnt, vedge;
    logic [31:0] bq, br, ra, rb;
    int          sel;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 33};
    vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33};
    vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[5] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);

    for (int i = 0; i < 6; i++) check_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = 32'd0;
      else if (sel < 3)  rb = $urandom_range(1, 255);
      else if (sel == 3) rb = 32'd1;
      else               rb = $urandom;
      if (sel == 4) ra = $urandom_range(0, 1000);
      check_vec(model(ra, rb), $sformatf("rnd%0d", i));
    end

    // Busy: extra starts during RUN and in DONE must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    vcnt = 0; vedge = -1; bq = '0; br = '1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 5) || (i == 33);
      dividend = 32'd7; divisor = 32'd2;
      @(posedge clk); #1;
      if (valid) begin
        vcnt++; vedge = i; bq = quotient; br = remainder;
      end
    end
    start = 1'b0;
    chk("busy_valid_count", 32'(vcnt), 32'd1);
    chk("busy_valid_edge", 32'(vedge), 32'd33);
    chk("busy_quot", bq, 32'd100);
    chk("busy_rem", br, 32'd0);
    chk("busy_ready_after", {31'b0, ready}, 32'd1);

    // Asynchronous reset partway through a division
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'b0, ready}, 32'd1);
    chk("arst_valid", {31'b0, valid}, 32'd0);
    chk("arst_quot", quotient, 32'd0);
    chk("arst_rem", remainder, 32'd0);
    chk("arst_dbz", {31'b0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
    end
    chk("arst_no_valid", 32'(vcnt), 32'd0);
    check_vec('{32'd50, 32'd3, 32'd16, 32'd2, 1'b0, 33}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_div_restoring32

`default_nettype wire
